// File: rtl/vrased_rst_ctrl.sv
// ----------------------------------------------------------------------------
// vrased_rst_ctrl
//
// Reset controller placed after the VRASED hardware monitors (DMA/secure
// stack, atomicity, key access). Any monitor request forces a system reset.
// The reset is held for at least HOLD_CYCLES cycles after the last request.
// It is then kept asserted until the CPU PC reaches the reset handler with no
// request pending. The controller also keeps a sticky record of the causes and
// a saturating count of RUN->HOLD entries.
//
// Configuration macro:
//   VRASED_RST_FASTPATH_EN - when defined, a request seen in RUN also asserts
//                            sys_rst combinationally in the same cycle. When
//                            undefined, sys_rst is purely registered.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   viol_req   in   [NUM_SRC] per-monitor reset requests (level, active-high)
//   pc         in   [16] current CPU program counter
//   cause_clr  in   single-cycle cause clear pulse (only honoured in RUN)
//   sys_rst    out  system reset to the CPU core, active-high
//   cause      out  [NUM_SRC] sticky OR of the requests behind the last reset
//   viol_cnt   out  [8] saturating count of RUN->HOLD entries
//   running    out  high while the controller is in RUN
// ----------------------------------------------------------------------------
module vrased_rst_ctrl #(
  parameter int          NUM_SRC       = 4,
  parameter int          HOLD_CYCLES   = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] viol_req,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               sys_rst,
  output logic [NUM_SRC-1:0] cause,
  output logic [7:0]         viol_cnt,
  output logic               running
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] WAIT_HDL = 2'd2;

  // The counter counts down to zero, so a load of HOLD_CYCLES-1 gives
  // exactly HOLD_CYCLES cycles in HOLD.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [1:0]         state_reg, state_next;
  logic [7:0]         hold_cnt_reg, hold_cnt_next;
  logic [NUM_SRC-1:0] cause_reg, cause_next;
  logic [7:0]         viol_cnt_reg, viol_cnt_next;
  logic               sys_rst_reg;
  logic               running_reg;
  logic               any_viol;

  assign any_viol = |viol_req;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    cause_next    = cause_reg;
    viol_cnt_next = viol_cnt_reg;
    case (state_reg)
      RUN: begin
        if (any_viol) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
          // A clear arriving with a violation drops the stale bits but
          // still records the new request.
          cause_next    = cause_clr ? viol_req : (cause_reg | viol_req);
          viol_cnt_next = (viol_cnt_reg == 8'hFF) ? 8'hFF : viol_cnt_reg + 8'd1;
        end else if (cause_clr) begin
          cause_next = '0;
        end
      end
      HOLD: begin
        if (any_viol) begin
          hold_cnt_next = HOLD_LOAD;
          cause_next    = cause_reg | viol_req;
        end else if (hold_cnt_reg == 8'd0) begin
          state_next = WAIT_HDL;
        end else begin
          hold_cnt_next = hold_cnt_reg - 8'd1;
        end
      end
      WAIT_HDL: begin
        // A request pending at handler entry takes precedence over release.
        if (any_viol) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
          cause_next    = cause_reg | viol_req;
        end else if (pc == RESET_HANDLER) begin
          state_next = RUN;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the safe, reset-asserted state.
        state_next = WAIT_HDL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_HDL;
      hold_cnt_reg <= 8'd0;
      cause_reg    <= '0;
      viol_cnt_reg <= 8'd0;
      sys_rst_reg  <= 1'b1;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      cause_reg    <= cause_next;
      viol_cnt_reg <= viol_cnt_next;
      sys_rst_reg  <= (state_next != RUN);
      running_reg  <= (state_next == RUN);
    end
  end

`ifdef VRASED_RST_FASTPATH_EN
  // Assert reset in the same cycle a violation is presented in RUN, so no
  // access can complete during the registration cycle.
  assign sys_rst = sys_rst_reg | (running_reg & any_viol);
`else
  assign sys_rst = sys_rst_reg;
`endif

  assign cause    = cause_reg;
  assign viol_cnt = viol_cnt_reg;
  assign running  = running_reg;

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vrased_rst_ctrl
//
// Self-checking bench for vrased_rst_ctrl with default parameters
// (NUM_SRC=4, HOLD_CYCLES=8, RESET_HANDLER=0). Table vectors hold inputs and
// the outputs expected after the next clock edge. Hand-written loops cover
// counter saturation and the same-cycle behaviour of sys_rst.
// ----------------------------------------------------------------------------
module tb_vrased_rst_ctrl;

`ifdef VRASED_RST_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  viol_req;
  logic [15:0] pc;
  logic        cause_clr;
  logic        sys_rst;
  logic [3:0]  cause;
  logic [7:0]  viol_cnt;
  logic        running;

  vrased_rst_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .viol_req  (viol_req),
    .pc        (pc),
    .cause_clr (cause_clr),
    .sys_rst   (sys_rst),
    .cause     (cause),
    .viol_cnt  (viol_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  viol;
    logic [15:0] pc;
    logic        clr;
    int          rep;
    logic        sys_rst;
    logic        running;
    logic [3:0]  cause;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    int          id;
    logic        sys_rst;
    logic        running;
    logic [3:0]  cause;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[29];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [15:0] p, logic c, int n,
                              logic s, logic run, logic [3:0] ca, logic [7:0] cn);
    vec_t t;
    t.rst = r; t.viol = v; t.pc = p; t.clr = c; t.rep = n;
    t.sys_rst = s; t.running = run; t.cause = ca; t.cnt = cn;
    return t;
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    if (sys_rst !== e.sys_rst || running !== e.running ||
        cause !== e.cause || viol_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL vec%0d: got sys_rst=%b running=%b cause=%h cnt=%0d, expected sys_rst=%b running=%b cause=%h cnt=%0d",
               e.id, sys_rst, running, cause, viol_cnt, e.sys_rst, e.running, e.cause, e.cnt);
    end else begin
      $display("vec%0d ok: sys_rst=%b running=%b cause=%h cnt=%0d",
               e.id, sys_rst, running, cause, viol_cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs and
  // compare shortly after the edge.
  task automatic apply(input int id, input logic r, input logic [3:0] v, input logic [15:0] p,
                       input logic c, input logic s, input logic run,
                       input logic [3:0] ca, input logic [7:0] cn);
    exp_t e;
    @(negedge clk);
    rst = r; viol_req = v; pc = p; cause_clr = c;
    e.id = id; e.sys_rst = s; e.running = run; e.cause = ca; e.cnt = cn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] exp_cnt;
    rst = 1'b1; viol_req = 4'h0; pc = 16'hE000; cause_clr = 1'b0;

    // Power-up and release
    tbl[0]  = mk(1, 4'h0, 16'hE000, 0, 2, 1, 0, 4'h0, 8'd0);
    tbl[1]  = mk(0, 4'h0, 16'hE000, 0, 5, 1, 0, 4'h0, 8'd0);
    tbl[2]  = mk(0, 4'h0, 16'h0000, 0, 1, 0, 1, 4'h0, 8'd0);
    tbl[3]  = mk(0, 4'h0, 16'hE000, 0, 2, 0, 1, 4'h0, 8'd0);
    // Single violation: 8 HOLD cycles (pc=0 ignored there), WAIT_HDL, RUN
    tbl[4]  = mk(0, 4'h1, 16'hE000, 0, 1, 1, 0, 4'h1, 8'd1);
    tbl[5]  = mk(0, 4'h0, 16'h0000, 0, 7, 1, 0, 4'h1, 8'd1);
    tbl[6]  = mk(0, 4'h0, 16'h0000, 0, 1, 1, 0, 4'h1, 8'd1);
    tbl[7]  = mk(0, 4'h0, 16'h0000, 0, 1, 0, 1, 4'h1, 8'd1);
    // Extension: second request three cycles in, HOLD totals 11 cycles
    tbl[8]  = mk(0, 4'h1, 16'hE000, 0, 1, 1, 0, 4'h1, 8'd2);
    tbl[9]  = mk(0, 4'h0, 16'h0000, 0, 2, 1, 0, 4'h1, 8'd2);
    tbl[10] = mk(0, 4'h4, 16'h0000, 0, 1, 1, 0, 4'h5, 8'd2);
    tbl[11] = mk(0, 4'h0, 16'h0000, 0, 7, 1, 0, 4'h5, 8'd2);
    tbl[12] = mk(0, 4'h0, 16'h0000, 0, 1, 1, 0, 4'h5, 8'd2);
    tbl[13] = mk(0, 4'h0, 16'h0000, 0, 1, 0, 1, 4'h5, 8'd2);
    // Request at handler entry in WAIT_HDL goes back to HOLD
    tbl[14] = mk(0, 4'h1, 16'hE000, 0, 1, 1, 0, 4'h5, 8'd3);
    tbl[15] = mk(0, 4'h0, 16'hE000, 0, 8, 1, 0, 4'h5, 8'd3);
    tbl[16] = mk(0, 4'h2, 16'h0000, 0, 1, 1, 0, 4'h7, 8'd3);
    tbl[17] = mk(0, 4'h0, 16'h0000, 0, 7, 1, 0, 4'h7, 8'd3);
    tbl[18] = mk(0, 4'h0, 16'h0000, 0, 1, 1, 0, 4'h7, 8'd3);
    tbl[19] = mk(0, 4'h0, 16'h0000, 0, 1, 0, 1, 4'h7, 8'd3);
    // Clear together with a request: request wins, stale bits dropped
    tbl[20] = mk(0, 4'h8, 16'hE000, 1, 1, 1, 0, 4'h8, 8'd4);
    tbl[21] = mk(0, 4'h0, 16'h0000, 1, 1, 1, 0, 4'h8, 8'd4);
    tbl[22] = mk(0, 4'h0, 16'h0000, 0, 6, 1, 0, 4'h8, 8'd4);
    tbl[23] = mk(0, 4'h0, 16'hE000, 0, 1, 1, 0, 4'h8, 8'd4);
    tbl[24] = mk(0, 4'h0, 16'h0000, 1, 1, 0, 1, 4'h8, 8'd4);
    // Clear in RUN
    tbl[25] = mk(0, 4'h0, 16'hE000, 1, 1, 0, 1, 4'h0, 8'd4);
    // rst mid-HOLD returns to WAIT_HDL and clears the record
    tbl[26] = mk(0, 4'h1, 16'hE000, 0, 1, 1, 0, 4'h1, 8'd5);
    tbl[27] = mk(1, 4'h0, 16'h0000, 0, 1, 1, 0, 4'h0, 8'd0);
    tbl[28] = mk(0, 4'h0, 16'h0000, 0, 1, 0, 1, 4'h0, 8'd0);

    for (int i = 0; i < 29; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        apply(i, tbl[i].rst, tbl[i].viol, tbl[i].pc, tbl[i].clr,
              tbl[i].sys_rst, tbl[i].running, tbl[i].cause, tbl[i].cnt);
      end
    end

    // Saturation: 300 full RUN->HOLD->WAIT_HDL->RUN loops
    exp_cnt = 8'd0;
    for (int n = 0; n < 300; n++) begin
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      apply(100, 0, 4'h1, 16'hE000, 0, 1, 0, 4'h1, exp_cnt);
      for (int k = 0; k < 8; k++) apply(101, 0, 4'h0, 16'h0000, 0, 1, 0, 4'h1, exp_cnt);
      apply(102, 0, 4'h0, 16'h0000, 0, 0, 1, 4'h1, exp_cnt);
    end
    apply(103, 0, 4'h0, 16'hE000, 1, 0, 1, 4'h0, 8'hFF);

    // Same-cycle sys_rst response to a request in RUN
    @(negedge clk);
    viol_req = 4'h1; cause_clr = 1'b0; pc = 16'hE000;
    #1;
    vectors++;
    if (sys_rst !== FAST) begin
      miscompares++;
      $display("FAIL same_cycle: got sys_rst=%b, expected %b", sys_rst, FAST);
    end else begin
      $display("same_cycle ok: sys_rst=%b", sys_rst);
    end
    begin
      exp_t e;
      e.id = 104; e.sys_rst = 1'b1; e.running = 1'b0; e.cause = 4'h1; e.cnt = 8'hFF;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
